down_count_timer: RTL and testbench
===================================

// Module: down_count_timer
//
// PURPOSE
//   Synchronous, loadable down-counter/timer. It is the count-down companion to the
//   4-bit ripple up-counter.
//   - Counts from a loaded value to zero.
//   - Pulses a terminal-count strobe when it reaches zero.
//   - Either stops there (one-shot) or reloads and repeats (periodic).
//   Used as an interval/timeout generator next to the counter blocks. All outputs are
//   in the clk domain; nothing is clocked by a count bit.
//
// PARAMETERS
//   WIDTH   4   counter width in bits; reload range 0 .. 2**WIDTH-1
//
// PORTS
//   clk          in   1      clock; all state updates on the rising edge
//   rst          in   1      reset, asynchronous, active-high
//   load         in   1      load load_val into the reload register and into count
//   load_val     in   WIDTH  value taken when load=1
//   start        in   1      begin or resume counting
//   stop         in   1      pause counting; count is held
//   auto_reload  in   1      1 = periodic mode, 0 = one-shot mode
//   count        out  WIDTH  current count (registered)
//   countbar     out  WIDTH  ~count (combinational)
//   tc           out  1      terminal-count strobe; high exactly in the cycles where count==0 after a RUN decrement
//   busy         out  1      1 while in state RUN
//   done         out  1      sticky: 1 in state DONE
//
// BEHAVIOUR
//   Reset (async, any time, including mid-count):
//     - count=0, countbar={WIDTH{1}}, reload_reg=0.
//     - state=IDLE, tc=0, busy=0, done=0.
//   States: IDLE, RUN, PAUSED, DONE. Input priority each edge: load > stop > start.
//   Any state, load=1:
//     - reload_reg<=load_val, count<=load_val, state->IDLE.
//     - tc<=0, done<=0. start and stop in the same cycle are ignored.
//   IDLE:
//     - start & count!=0 -> RUN. count is unchanged on that edge.
//     - start & count==0 -> stays IDLE; no tc.
//   RUN, per edge:
//     - stop -> PAUSED, count held.
//     - count>1 -> count-1.
//     - count==1 -> count<=0, tc<=1.
//     - count==0 (the tc cycle):
//         * auto_reload=1 & reload_reg!=0: count<=reload_reg, stay RUN, tc<=0.
//         * otherwise: state->DONE, tc<=0, done<=1.
//       auto_reload is sampled only in this cycle.
//     - stop during the tc cycle -> PAUSED at count 0; that tc pulse still completes.
//   PAUSED:
//     - stop wins over start.
//     - start alone -> RUN, decrement resumes on the next edge.
//     - resume at count 0 -> RUN, then takes the count==0 path above; no second tc.
//   DONE:
//     - start & reload_reg!=0 -> count<=reload_reg, state->RUN, done<=0.
//     - start & reload_reg==0 -> stays DONE.
//     - stop -> ignored.
//   Timing and width rules:
//     - Latency: start on edge k gives count==0 and tc=1 after edge k+N (N = loaded value).
//     - Periodic mode: tc period = N+1 cycles. Sequence is N, N-1, .., 1, 0, N, ..
//     - count never wraps below 0. Decrement is modulo-free WIDTH-bit subtraction guarded by count!=0.
//     - busy=(state==RUN). done=(state==DONE).
//
// TESTING (WIDTH=4)
//   1. rst pulsed mid-RUN at count=5, asynchronous to clk
//      -> count=0, countbar=4'hF, tc=busy=done=0 immediately, without waiting for an edge.
//   2. load_val=3, load, then start on edge k, auto_reload=0
//      -> count 3,2,1,0 on edges k..k+3; tc=1 only after edge k+3; done=1, busy=0 from edge k+4.
//   3. load_val=2, auto_reload=1, start
//      -> count 2,1,0,2,1,0,...; tc every 3 cycles; done never set.
//   4. load_val=9, start, stop at count=6 for 4 cycles, then start
//      -> count held at 6 with busy=0 while paused; then 5,4,..,0 with a single tc.
//   5. load asserted with start and stop in the same cycle while RUN at count=7, load_val=4
//      -> count=4, state IDLE, busy=0, tc=0.
//   6. load_val=0, start
//      -> remains IDLE, no tc. load_val=15, one-shot
//      -> tc exactly 15 edges after the start edge; countbar==~count every cycle.

Source files
------------

// File: rtl/down_count_timer_if.sv
// Control and status bundle for the down-count timer.
// Latency: none, this is wiring only.
// Backpressure: none; the controls are level inputs that the timer samples on every clk edge.
interface down_count_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] countbar;
    logic             tc;
    logic             busy;
    logic             done;

    // Controller side: drives the controls and observes the count and status.
    modport master (
        output load, load_val, start, stop, auto_reload,
        input  count, countbar, tc, busy, done
    );

    // Timer side.
    modport slave (
        input  load, load_val, start, stop, auto_reload,
        output count, countbar, tc, busy, done
    );
endinterface

// File: rtl/down_count_timer.sv
// Loadable down-counter with a terminal-count strobe, in one-shot or periodic mode.
// Latency: a start on edge k gives count==0 and tc=1 after edge k+N, where N is the loaded value.
// Backpressure: none; stop pauses counting, and load overrides everything else in the same cycle.
module down_count_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    down_count_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic             tc, tc_nxt;

    // State register; an asynchronous reset clears everything without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    // Next-state logic with input priority load > stop > start.
    // tc defaults low, so it is a single-cycle pulse set only on the 1 -> 0 decrement.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (bus.load) begin
            reload_nxt = bus.load_val;
            count_nxt  = bus.load_val;
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // A zero count cannot start, so no tc is produced from IDLE at zero.
                    if (bus.start && !bus.stop && count != '0)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        // A stop in the tc cycle still lets that tc pulse finish; tc drops on this edge.
                        state_nxt = PAUSED;
                    end else if (count > WIDTH'(1)) begin
                        count_nxt = count - WIDTH'(1);
                    end else if (count == WIDTH'(1)) begin
                        count_nxt = '0;
                        tc_nxt    = 1'b1;
                    end else if (bus.auto_reload && reload_reg != '0) begin
                        // Periodic mode: the count sequence is N .. 1, 0, N.
                        count_nxt = reload_reg;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                PAUSED: begin
                    if (!bus.stop && bus.start)
                        state_nxt = RUN;
                end
                DONE: begin
                    // stop has no effect here; a restart needs a non-zero reload value.
                    if (bus.start && reload_reg != '0) begin
                        count_nxt = reload_reg;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.count    = count;
    assign bus.countbar = ~count;
    assign bus.tc       = tc;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_down_count_timer.sv
// Directed tests for down_count_timer with hand-computed expected values.
// Inputs change 1 ns after the rising edge, and outputs are sampled at that same point.
module tb_down_count_timer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    down_count_timer_if #(.WIDTH(4)) bus ();

    down_count_timer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load        = 1'b0;
        bus.load_val    = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v, input logic ar);
        bus.load        = 1'b1;
        bus.load_val    = v;
        bus.auto_reload = ar;
        step();
        bus.load        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.count !== 4'd0 || bus.countbar !== 4'hF || bus.tc !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: count=%0d countbar=%h tc=%b busy=%b done=%b, required 0/F/0/0/0",
                     bus.count, bus.countbar, bus.tc, bus.busy, bus.done);
        end
    endtask

    task automatic test_async_reset();
        do_load(4'd9, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (bus.count !== 4'd5 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_count: count=%0d busy=%b, required 5/1", bus.count, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.count !== 4'd0 || bus.countbar !== 4'hF || bus.tc !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: count=%0d countbar=%h tc=%b busy=%b done=%b, required 0/F/0/0/0",
                     bus.count, bus.countbar, bus.tc, bus.busy, bus.done);
        end
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_cnt [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        do_load(4'd3, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (bus.count !== exp_cnt[i] || bus.tc !== (i == 3) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL one_shot_edge%0d: count=%0d tc=%b busy=%b done=%b, required %0d/%0b/1/0",
                         i, bus.count, bus.tc, bus.busy, bus.done, exp_cnt[i], (i == 3));
            end
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.count !== 4'd0) begin
            n_err++;
            $display("FAIL one_shot_done: done=%b busy=%b tc=%b count=%0d, required 1/0/0/0",
                     bus.done, bus.busy, bus.tc, bus.count);
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_cnt [8] = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1};
        do_load(4'd2, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (bus.count !== exp_cnt[i] || bus.tc !== (exp_cnt[i] == 4'd0) || bus.done !== 1'b0 ||
                bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL periodic_edge%0d: count=%0d tc=%b done=%b busy=%b, required %0d/%0b/0/1",
                         i, bus.count, bus.tc, bus.done, bus.busy, exp_cnt[i], (exp_cnt[i] == 4'd0));
            end
        end
        bus.auto_reload = 1'b0;
    endtask

    task automatic test_pause_resume();
        int tcs;
        do_load(4'd9, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (bus.count !== 4'd6 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
                n_err++;
                $display("FAIL paused_cycle%0d: count=%0d busy=%b tc=%b, required 6/0/0",
                         i, bus.count, bus.busy, bus.tc);
            end
        end
        bus.stop  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.count !== 4'd6 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL resume_edge: count=%0d busy=%b, required 6/1", bus.count, bus.busy);
        end
        tcs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.tc === 1'b1) tcs++;
            n_cmp++;
            if (bus.count !== 4'(5 - i)) begin
                n_err++;
                $display("FAIL resume_count%0d: count=%0d, required %0d", i, bus.count, 5 - i);
            end
        end
        step();
        if (bus.tc === 1'b1) tcs++;
        n_cmp++;
        if (tcs != 1 || bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL resume_tc_count: tc pulses=%0d done=%b, required 1/1", tcs, bus.done);
        end
    endtask

    task automatic test_load_override();
        do_load(4'd10, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (bus.count !== 4'd7 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_load_count: count=%0d busy=%b, required 7/1", bus.count, bus.busy);
        end
        bus.load     = 1'b1;
        bus.load_val = 4'd4;
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        step();
        idle_inputs();
        n_cmp++;
        if (bus.count !== 4'd4 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL load_override: count=%0d busy=%b tc=%b done=%b, required 4/0/0/0",
                     bus.count, bus.busy, bus.tc, bus.done);
        end
        step();
        n_cmp++;
        if (bus.count !== 4'd4 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_stays_idle: count=%0d busy=%b, required 4/0", bus.count, bus.busy);
        end
    endtask

    task automatic test_boundaries();
        int edges;
        bit seen;
        do_load(4'd0, 1'b1);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.count !== 4'd0) begin
                n_err++;
                $display("FAIL zero_start%0d: busy=%b tc=%b count=%0d, required 0/0/0",
                         i, bus.busy, bus.tc, bus.count);
            end
        end
        bus.start = 1'b0;
        do_load(4'd15, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            n_cmp++;
            if (bus.countbar !== ~bus.count) begin
                n_err++;
                $display("FAIL countbar_cycle%0d: countbar=%h count=%h", i, bus.countbar, bus.count);
            end
            if (bus.tc === 1'b1) seen = 1'b1;
            else begin
                step();
                edges++;
            end
        end
        n_cmp++;
        if (!seen || edges != 15 || bus.count !== 4'd0) begin
            n_err++;
            $display("FAIL tc_latency_15: seen=%0b edges=%0d count=%0d, required 1/15/0",
                     seen, edges, bus.count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        test_reset();
        test_async_reset();
        test_one_shot();
        test_periodic();
        test_pause_resume();
        test_load_override();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
